// File: rtl/add_sched_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | add_sched_pkg                                                            |
// | Shared op and state encodings for the add-unit scheduler.                |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package add_sched_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/add_unit_scheduler_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_arbiter                                                               |
// | Combinational round-robin: first request at or after ptr, cyclically.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module rr_arbiter
  import add_sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grant_idx,
  output logic                    any
);

  localparam int IDX_W = $clog2(NREQ);

  // One extra bit so ptr + offset can exceed NREQ-1 before wrapping.
  logic [IDX_W:0] w_pos;

  assign any = |req;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_pos     = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_pos = {1'b0, ptr} + (IDX_W+1)'(i);
      if (w_pos >= (IDX_W+1)'(NREQ)) begin
        w_pos = w_pos - (IDX_W+1)'(NREQ);
      end
      if ((grant == '0) && req[w_pos[IDX_W-1:0]]) begin
        grant[w_pos[IDX_W-1:0]] = 1'b1;
        grant_idx               = w_pos[IDX_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/add_unit_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | add_unit_scheduler                                                       |
// | Round-robin sharing of one multi-cycle add/sub unit, with watchdog.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module add_unit_scheduler
  import add_sched_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int DATA_W   = 32,
  parameter int TAG_W    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*3-1:0]        req_op,
  input  logic [NREQ*DATA_W-1:0]   req_a,
  input  logic [NREQ*DATA_W-1:0]   req_b,
  input  logic [NREQ*TAG_W-1:0]    req_tag,
  output logic                     unit_start,
  output logic [2:0]               unit_op,
  output logic [DATA_W-1:0]        unit_a,
  output logic [DATA_W-1:0]        unit_b,
  input  logic                     unit_valid,
  input  logic [DATA_W-1:0]        unit_result,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [DATA_W-1:0]        res_data,
  output logic [TAG_W-1:0]         res_tag,
  output logic [$clog2(NREQ)-1:0]  res_src,
  output logic                     res_err,
  output logic                     busy,
  output logic                     err_timeout
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] C_MAX_WAIT = CNT_W'(MAX_WAIT);
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NREQ - 1);

  sched_state_t r_state, w_state_next;

  logic [IDX_W-1:0]  r_ptr, r_src, w_grant_idx;
  logic [NREQ-1:0]   w_grant;
  logic              w_any, w_accept, w_timeout;
  logic [CNT_W-1:0]  r_cnt, w_cnt_inc;
  logic [2:0]        r_op;
  logic [DATA_W-1:0] r_a, r_b, r_res_data;
  logic [TAG_W-1:0]  r_tag;
  logic              r_res_err, r_err_timeout;

  logic [2:0]        w_op_arr  [NREQ];
  logic [DATA_W-1:0] w_a_arr   [NREQ];
  logic [DATA_W-1:0] w_b_arr   [NREQ];
  logic [TAG_W-1:0]  w_tag_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign w_op_arr[gi]  = req_op[gi*3 +: 3];
    assign w_a_arr[gi]   = req_a[gi*DATA_W +: DATA_W];
    assign w_b_arr[gi]   = req_b[gi*DATA_W +: DATA_W];
    assign w_tag_arr[gi] = req_tag[gi*TAG_W +: TAG_W];
  end

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req       (req_valid),
    .ptr       (r_ptr),
    .grant     (w_grant),
    .grant_idx (w_grant_idx),
    .any       (w_any)
  );

  // Reset is gated in so no handshake completes while rst_n is low.
  assign w_accept  = rst_n && (r_state == IDLE) && w_any;
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_timeout = (r_state == BUSY) && !unit_valid && (w_cnt_inc == C_MAX_WAIT);

  always_comb begin
    w_state_next = r_state;
    req_ready    = '0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          req_ready    = w_grant;
          w_state_next = ISSUE;
        end
      end
      ISSUE:   w_state_next = BUSY;
      BUSY:    if (unit_valid || w_timeout) w_state_next = DONE;
      DONE:    if (res_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_ptr         <= '0;
      r_src         <= '0;
      r_cnt         <= '0;
      r_op          <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_tag         <= '0;
      r_res_data    <= '0;
      r_res_err     <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_op  <= w_op_arr[w_grant_idx];
        r_a   <= w_a_arr[w_grant_idx];
        r_b   <= w_b_arr[w_grant_idx];
        r_tag <= w_tag_arr[w_grant_idx];
        r_src <= w_grant_idx;
        r_ptr <= (w_grant_idx == C_LAST_IDX) ? '0 : w_grant_idx + 1'b1;
      end
      if (r_state == ISSUE) begin
        r_cnt <= '0;
      end else if (r_state == BUSY) begin
        r_cnt <= w_cnt_inc;
      end
      // A result arriving on the watchdog's last cycle still wins.
      if ((r_state == BUSY) && unit_valid) begin
        r_res_data <= unit_result;
        r_res_err  <= 1'b0;
      end else if (w_timeout) begin
        r_res_data    <= '0;
        r_res_err     <= 1'b1;
        r_err_timeout <= 1'b1;
      end
    end
  end

  assign unit_start  = (r_state == ISSUE);
  assign unit_op     = r_op;
  assign unit_a      = r_a;
  assign unit_b      = r_b;
  assign res_valid   = (r_state == DONE);
  assign res_data    = r_res_data;
  assign res_tag     = r_tag;
  assign res_src     = r_src;
  assign res_err     = r_res_err;
  assign busy        = (r_state != IDLE);
  assign err_timeout = r_err_timeout;

endmodule
`default_nettype wire

// File: doc/add_unit_scheduler.md
# add_unit_scheduler

Shares one multi-cycle add/sub execution unit (start/valid interface, one operation in flight) among NREQ requesters, such as reservation stations or decode slots. The block runs a round-robin grant, registers the winner's operands and issues them with a one-cycle start pulse. It waits for the unit's valid, holds the result in a one-entry output buffer until it is accepted, and tags the result with the requester index and the requester-supplied tag. A watchdog returns an error result if the unit never responds.

## Interface
- NREQ, 4: number of requesters (2..8)
- DATA_W, 32: operand/result width
- TAG_W, 4: requester tag width
- MAX_WAIT, 8: cycles after unit_start before timeout
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  NREQ  per-requester request
- req_ready  out  NREQ  one-hot grant/accept, 0 outside IDLE
- req_op  in  NREQ*3  op, slice i at [i*3 +: 3]; 0=add, 1=sub, others passed through unchanged
- req_a, req_b  in  NREQ*DATA_W  operands, slice i at [i*DATA_W +: DATA_W]
- req_tag  in  NREQ*TAG_W  caller tag
- unit_start  out  1  one-cycle issue pulse
- unit_op  out  3  registered op
- unit_a, unit_b  out  DATA_W  registered operands
- unit_valid  in  1  unit result strobe
- unit_result  in  DATA_W  unit result
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts
- res_data  out  DATA_W  result, 0 on timeout
- res_tag  out  TAG_W  tag of the completed request
- res_src  out  $clog2(NREQ)  index of the completed requester
- res_err  out  1  result produced by timeout
- busy  out  1  state != IDLE
- err_timeout  out  1  sticky timeout flag, cleared only by reset

## Operation
- FSM states: IDLE, ISSUE, BUSY, DONE.
- IDLE:
  - If any req_valid is high, grant the first set bit at or after pointer ptr, searching cyclically.
  - req_ready[g] is driven combinationally in the same cycle. The handshake completes then.
  - Latch op/a/b/tag/g and set ptr = (g+1) mod NREQ.
  - Go to ISSUE.
- ISSUE: unit_start=1 for exactly one cycle with the latched values; clear wait counter; go to BUSY.
- BUSY:
  - Wait counter increments each cycle.
  - On unit_valid: capture unit_result into res_data, res_err=0, go to DONE.
  - Else, when the counter reaches MAX_WAIT: res_data=0, res_err=1, set err_timeout, go to DONE.
  - If unit_valid and the counter reaching MAX_WAIT occur in the same cycle, unit_valid wins.
- DONE:
  - res_valid=1; res_data/res_tag/res_src/res_err are held stable.
  - On res_valid && res_ready, go to IDLE. No new grant is made in the DONE cycle.
- unit_valid outside BUSY is ignored; no state change.
- Requests not granted are not buffered; requesters hold req_valid until their req_ready.
- unit_op/a/b keep their last values outside ISSUE.

## Timing
- Reset value of every output and register is 0: req_ready, unit_start, unit_op/a/b, res_valid, res_data, res_tag, res_src, res_err, busy, err_timeout, ptr, counter. State resets to IDLE.
- Reset mid-operation aborts the operation; the in-flight request is lost and no result is produced.
- Cycle sequence, where t is the accept cycle:
  - unit_start at t+1.
  - unit returns valid k cycles after start, i.e. at t+1+k.
  - res_valid at t+2+k.
  - With the 2-cycle unit (k=2): res_valid at t+4; with res_ready=1, IDLE at t+5, next accept at t+5, giving a 5-cycle minimum period.
- Timeout: with no unit_valid, res_valid with res_err=1 at t+2+MAX_WAIT.
- req_ready has a combinational path from req_valid. Requesters must not make req_valid depend on req_ready.

## Structure
- Package add_sched_pkg: op encodings OP_ADD=3'd0, OP_SUB=3'd1; state encoding IDLE/ISSUE/BUSY/DONE.
- Sub-module rr_arbiter: combinational NREQ-bit round-robin. Inputs: request vector, ptr. Outputs: one-hot grant, grant index.
- Pointer update, FSM, watchdog and result buffer live in add_unit_scheduler.

## Test plan
- Single request: req 2 valid, op=0, a=5, b=7, tag=3; unit model k=2 -> unit_start at t+1 with a=5,b=7; res_valid at t+4, res_data=12, res_src=2, res_tag=3, res_err=0.
- Round-robin: all 4 req_valid held high, res_ready=1 -> grants in order 0,1,2,3,0, one every 5 cycles; subtraction a=3,b=5 -> res_data=32'hFFFFFFFE.
- Backpressure: res_ready=0 for 6 cycles after res_valid -> outputs stable, req_ready stays 0, no unit_start; accept on release -> IDLE next cycle.
- Timeout: unit model never responds -> res_valid at t+2+8, res_err=1, res_data=0, err_timeout stays 1 after the next normal transaction; unit_valid coincident with counter=MAX_WAIT -> normal result, err_timeout unchanged.
- Spurious unit_valid in IDLE -> no res_valid, state remains IDLE.
- Reset asserted in BUSY -> next cycle all outputs 0, state IDLE, ptr 0; a late unit_valid is ignored.
